// File: rtl/keypad_psswrd_entry.sv
`default_nettype none
// keypad_psswrd_entry (rev 1.0): collects two BCD keypad digits into a held password attempt,
// with clear/enter/invalid-key handling, a one-cycle submit strobe and an inactivity timeout.
module keypad_psswrd_entry #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       sensor_1,
   output logic [7:0] psswrd_atmpt,
   output logic       try_psswrd,
   output logic [1:0] digit_cnt,
   output logic       entry_timeout,
   output logic       key_err
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT_D0 = 3'd1,
      WAIT_D1 = 3'd2,
      READY   = 3'd3,
      SUBMIT  = 3'd4
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]      KEY_CLEAR = 4'hA;
   localparam logic [3:0]      KEY_ENTER = 4'hB;

   state_t          state;
   state_t          state_nxt;
   logic            key_valid_q;
   logic [TO_W-1:0] to_cnt;
   logic [TO_W-1:0] to_cnt_nxt;
   logic [7:0]      atmpt_nxt;
   logic [1:0]      cnt_nxt;
   logic            try_nxt;
   logic            timeout_nxt;
   logic            err_nxt;
   logic            key_ev;
   logic            is_digit;
   logic            is_clear;
   logic            is_enter;

   // One event per press: only the rising edge of the held key level counts.
   assign key_ev   = key_valid & ~key_valid_q;
   assign is_digit = (key_code <= 4'd9);
   assign is_clear = (key_code == KEY_CLEAR);
   assign is_enter = (key_code == KEY_ENTER);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         key_valid_q   <= 1'b0;
         to_cnt        <= '0;
         psswrd_atmpt  <= 8'h00;
         digit_cnt     <= 2'd0;
         try_psswrd    <= 1'b0;
         entry_timeout <= 1'b0;
         key_err       <= 1'b0;
      end else begin
         state         <= state_nxt;
         key_valid_q   <= key_valid;
         to_cnt        <= to_cnt_nxt;
         psswrd_atmpt  <= atmpt_nxt;
         digit_cnt     <= cnt_nxt;
         try_psswrd    <= try_nxt;
         entry_timeout <= timeout_nxt;
         key_err       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      atmpt_nxt   = psswrd_atmpt;
      cnt_nxt     = digit_cnt;
      try_nxt     = 1'b0;
      timeout_nxt = 1'b0;
      err_nxt     = 1'b0;
      // Counter stays cleared unless a counting state idles without a key event.
      to_cnt_nxt  = '0;

      if (state == IDLE) begin
         atmpt_nxt = 8'h00;
         cnt_nxt   = 2'd0;
         if (sensor_1) begin
            state_nxt = WAIT_D0;
         end
      end else if (!sensor_1) begin
         state_nxt = IDLE;
         atmpt_nxt = 8'h00;
         cnt_nxt   = 2'd0;
      end else begin
         case (state)
            WAIT_D0: begin
               if (key_ev) begin
                  if (is_digit) begin
                     atmpt_nxt = {key_code, 4'h0};
                     cnt_nxt   = 2'd1;
                     state_nxt = WAIT_D1;
                  end else if (is_clear) begin
                     atmpt_nxt = 8'h00;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end
            end

            WAIT_D1: begin
               if (key_ev) begin
                  if (is_digit) begin
                     atmpt_nxt = {psswrd_atmpt[7:4], key_code};
                     cnt_nxt   = 2'd2;
                     state_nxt = READY;
                  end else if (is_clear) begin
                     atmpt_nxt = 8'h00;
                     cnt_nxt   = 2'd0;
                     state_nxt = WAIT_D0;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  atmpt_nxt   = 8'h00;
                  cnt_nxt     = 2'd0;
                  timeout_nxt = 1'b1;
                  state_nxt   = WAIT_D0;
               end else begin
                  to_cnt_nxt = to_cnt + 1'b1;
               end
            end

            READY: begin
               if (key_ev) begin
                  if (is_enter) begin
                     try_nxt   = 1'b1;
                     state_nxt = SUBMIT;
                  end else if (is_clear) begin
                     atmpt_nxt = 8'h00;
                     cnt_nxt   = 2'd0;
                     state_nxt = WAIT_D0;
                  end else begin
                     err_nxt = 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  atmpt_nxt   = 8'h00;
                  cnt_nxt     = 2'd0;
                  timeout_nxt = 1'b1;
                  state_nxt   = WAIT_D0;
               end else begin
                  to_cnt_nxt = to_cnt + 1'b1;
               end
            end

            SUBMIT: begin
               // The submitted value stays on psswrd_atmpt until the next digit lands.
               cnt_nxt   = 2'd0;
               state_nxt = WAIT_D0;
            end

            default: begin
               atmpt_nxt = 8'h00;
               cnt_nxt   = 2'd0;
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_psswrd_entry.sv
`default_nettype none
// tb_keypad_psswrd_entry: directed and randomized keypad stimulus; a per-cycle
// expectation queue filled from a behavioural model is drained by an output monitor.
module tb_keypad_psswrd_entry;

   localparam int T  = 16;
   localparam int TW = 5;

   logic       clk       = 1'b0;
   logic       rst       = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code  = 4'h0;
   logic       sensor_1  = 1'b0;
   logic [7:0] psswrd_atmpt;
   logic       try_psswrd;
   logic [1:0] digit_cnt;
   logic       entry_timeout;
   logic       key_err;

   keypad_psswrd_entry #(.TIMEOUT_CYCLES(T), .TO_W(TW)) dut (
      .clk          (clk),
      .rst          (rst),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .sensor_1     (sensor_1),
      .psswrd_atmpt (psswrd_atmpt),
      .try_psswrd   (try_psswrd),
      .digit_cnt    (digit_cnt),
      .entry_timeout(entry_timeout),
      .key_err      (key_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] atmpt;
      logic       try_p;
      logic [1:0] cnt;
      logic       to;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   passed = 0;

   // Model: whether a car session is open, the digits collected, a pending submit and quiet time.
   bit         m_prev;
   bit         m_present;
   bit         m_submit;
   int         m_ndig;
   int         m_quiet;
   logic [7:0] m_shown;

   function automatic logic [12:0] outs();
      return {psswrd_atmpt, try_psswrd, digit_cnt, entry_timeout, key_err};
   endfunction

   task automatic check(input string name, input logic [12:0] act, input logic [12:0] expv);
      checks++;
      if (act === expv) passed++;
      else $display("FAIL %s: got {atmpt,try,cnt,to,err}=%h required %h at %0t", name, act, expv, $time);
   endtask

   task automatic model_reset();
      m_prev = 0; m_present = 0; m_submit = 0; m_ndig = 0; m_quiet = 0; m_shown = 8'h00;
   endtask

   task automatic model(input logic kv, input logic [3:0] kc, input logic s1);
      bit   ev;
      exp_t e;
      ev = kv && !m_prev;
      m_prev = kv;
      e.try_p = 1'b0; e.to = 1'b0; e.err = 1'b0;
      if (!m_present) begin
         m_present = s1;
      end else if (!s1) begin
         m_present = 0; m_submit = 0; m_ndig = 0; m_shown = 8'h00; m_quiet = 0;
      end else if (m_submit) begin
         m_submit = 0; m_ndig = 0;
      end else if (ev) begin
         m_quiet = 0;
         if (kc <= 4'd9) begin
            if (m_ndig == 0) begin m_shown = {kc, 4'h0}; m_ndig = 1; end
            else if (m_ndig == 1) begin m_shown[3:0] = kc; m_ndig = 2; end
            else e.err = 1'b1;
         end else if (kc == 4'hA) begin
            m_shown = 8'h00; m_ndig = 0;
         end else if (kc == 4'hB && m_ndig == 2) begin
            m_submit = 1; e.try_p = 1'b1;
         end else begin
            e.err = 1'b1;
         end
      end else if (m_ndig > 0) begin
         if (m_quiet == T - 1) begin
            e.to = 1'b1; m_ndig = 0; m_shown = 8'h00; m_quiet = 0;
         end else begin
            m_quiet++;
         end
      end
      e.atmpt = m_shown;
      e.cnt   = 2'(m_ndig);
      exp_q.push_back(e);
   endtask

   task automatic step(input logic kv, input logic [3:0] kc, input logic s1);
      @(negedge clk);
      key_valid = kv; key_code = kc; sensor_1 = s1;
      model(kv, kc, s1);
   endtask

   task automatic press(input logic [3:0] kc, input int hold, input int gap, input logic s1 = 1'b1);
      for (int i = 0; i < hold; i++) step(1'b1, kc, s1);
      for (int i = 0; i < gap; i++) step(1'b0, 4'($urandom), s1);
   endtask

   task automatic idle(input int n, input logic s1 = 1'b1);
      for (int i = 0; i < n; i++) step(1'b0, 4'($urandom), s1);
   endtask

   task automatic release_reset();
      @(negedge clk);
      key_valid = 1'b0; sensor_1 = 1'b0; rst = 1'b1;
      model_reset();
      model(1'b0, key_code, 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      exp_q.delete();
      rst = 1'b0;
      #1;
      check("async_reset", outs(), 13'h0);
      repeat (2) @(negedge clk);
      check("reset_hold", outs(), 13'h0);
      release_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", outs(), e);
         end
      end
   end

   initial begin : stim
      model_reset();
      #12;
      check("reset_state", outs(), 13'h0);
      release_reset();

      // Straight entry 5,7,enter.
      step(1'b0, 4'h0, 1'b1);
      press(4'h5, 3, 2); press(4'h7, 3, 2); press(4'hB, 3, 2);
      idle(3);
      check("submit_held", {5'd0, psswrd_atmpt}, {5'd0, 8'h57});
      check("submit_cnt0", {11'd0, digit_cnt}, 13'd0);

      // Clear mid-entry, long hold counted once.
      press(4'h5, 2, 1); press(4'hA, 2, 1); press(4'h2, 2, 1);
      press(4'h3, 10, 2); press(4'hB, 1, 2);
      check("resubmit", {5'd0, psswrd_atmpt}, {5'd0, 8'h23});

      // Rejected keys and an early enter.
      press(4'h1, 2, 1); press(4'h2, 2, 1); press(4'h9, 2, 1); press(4'hE, 2, 1);
      check("no_overwrite", {5'd0, psswrd_atmpt}, {5'd0, 8'h12});
      press(4'hB, 1, 2); press(4'hB, 1, 2);

      // Inactivity timeout, then a key landing exactly on the expiry cycle.
      press(4'h4, 1, 0); idle(17);
      check("timeout_pulse", {12'd0, entry_timeout}, 13'd1);
      check("timeout_clear", {3'd0, psswrd_atmpt, digit_cnt}, 13'd0);
      idle(2);
      press(4'h4, 1, 0); idle(15); press(4'h7, 1, 2);
      check("expiry_key", {3'd0, psswrd_atmpt, digit_cnt}, {3'd0, 8'h47, 2'd2});
      press(4'hA, 1, 1);

      // Car leaves on the enter event.
      press(4'h8, 2, 1); press(4'h8, 2, 1);
      step(1'b1, 4'hB, 1'b0);
      idle(2, 1'b0);
      press(4'h3, 2, 1, 1'b0);
      check("sensor_drop", {3'd0, psswrd_atmpt, digit_cnt}, 13'd0);

      // Asynchronous reset mid-entry.
      step(1'b0, 4'h0, 1'b1);
      press(4'h3, 2, 1); press(4'h6, 2, 1);
      async_reset();
      idle(3, 1'b0);

      // Randomized sessions.
      idle(1);
      for (int n = 0; n < 400; n++) begin
         logic s;
         s = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 149) == 0) async_reset();
         else if ($urandom_range(0, 9) == 0) idle($urandom_range(10, 20), s);
         else press(4'($urandom), $urandom_range(1, 4), $urandom_range(0, 3), s);
      end

      idle(2);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", 13'(exp_q.size()), 13'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/keypad_psswrd_entry.md
Name: keypad_psswrd_entry

Overview:
- Upstream stage of the parking access controller: turns keypad key events into the 8-bit password attempt and the try strobe that the controller consumes.
- Collects two BCD digits while a car is detected at the entrance (sensor_1), and handles clear, enter, invalid keys and an inactivity timeout.
- Presents psswrd_atmpt held stable, with a single-cycle try_psswrd strobe per submission.

Parameters:
TIMEOUT_CYCLES, 1000, clock cycles of keypad inactivity (with at least one digit entered) before the partial entry is discarded
TO_W, 10, width of the timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low
key_valid  input  1  level from keypad scanner, high while a key is held; may stay high many cycles
key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC-0xF invalid; valid while key_valid=1
sensor_1  input  1  car present at entrance; enables entry
psswrd_atmpt  output  8  {first digit, second digit}, BCD
try_psswrd  output  1  one-cycle submit strobe
digit_cnt  output  2  digits held: 0, 1 or 2
entry_timeout  output  1  one-cycle pulse when a partial entry is discarded on timeout
key_err  output  1  one-cycle pulse on a rejected key

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0) immediately forces state IDLE and clears all outputs, key_valid_q and the timeout counter.
- Reset asserted mid-entry or during SUBMIT aborts the entry. No try_psswrd is produced.
- Key acceptance: key_valid is registered into key_valid_q.
  - A key event is the cycle where key_valid=1 and key_valid_q=0.
  - One event per press, regardless of hold length.
- All outputs are registered. A key event sampled at edge n updates the outputs visible after edge n.
- States:
  - IDLE: psswrd_atmpt=0, digit_cnt=0. When sensor_1=1 → WAIT_D0. Key events are ignored, with no key_err.
  - WAIT_D0:
    - digit d → psswrd_atmpt={d,4'h0}, digit_cnt=1, go to WAIT_D1.
    - clear → stay; psswrd_atmpt=0.
    - enter → stay; key_err pulse.
  - WAIT_D1:
    - digit d → psswrd_atmpt[3:0]=d, digit_cnt=2, go to READY.
    - clear → WAIT_D0; psswrd_atmpt=0, digit_cnt=0.
    - enter → key_err pulse; stay.
  - READY:
    - enter → SUBMIT.
    - clear → WAIT_D0; psswrd_atmpt=0, digit_cnt=0.
    - digit → key_err pulse; value unchanged (no overwrite).
  - SUBMIT:
    - try_psswrd=1 for exactly this one cycle; psswrd_atmpt unchanged.
    - Next edge → WAIT_D0 with digit_cnt=0.
    - psswrd_atmpt keeps the submitted value until the next digit is accepted.
    - A key event occurring in SUBMIT is dropped.
- Invalid codes 0xC-0xF in any entry state: key_err pulse, no other change.
- Timeout:
  - The counter runs only in WAIT_D1 and READY. It is cleared on every key event and on entry to those states.
  - When it reaches TIMEOUT_CYCLES-1 with no key event: go to WAIT_D0, psswrd_atmpt=0, digit_cnt=0, entry_timeout pulse for one cycle.
- sensor_1=0 in any non-IDLE state: go to IDLE next edge, clear psswrd_atmpt and digit_cnt, suppress any pending SUBMIT.
- Priority per cycle: rst > sensor_1 low > key event > timeout.
  - A key event on the same cycle as timeout expiry wins, and the counter clears.
- try_psswrd, entry_timeout and key_err are never high for two consecutive cycles.
- try_psswrd and entry_timeout are never high together.

Test Plan:
1. Reset, sensor_1=1, key presses 5, 7, enter (each held 3 cycles) → digit_cnt 1→2, psswrd_atmpt=0x57, try_psswrd high exactly 1 cycle after the enter edge, then digit_cnt=0 and psswrd_atmpt stays 0x57.
2. sensor_1=1; keys 5, clear, 2, 3, enter → psswrd_atmpt 0x50→0x00→0x20→0x23, single try_psswrd with 0x23; hold a key 10 cycles → counted once.
3. sensor_1=1; keys 1, 2, 9, 0xE, enter before two digits on a fresh entry → key_err pulses on 9, on 0xE and on the early enter; psswrd_atmpt stays 0x12 after the 9 and 0xE.
4. TIMEOUT_CYCLES=16; key 4 then idle 16 cycles → entry_timeout one pulse, psswrd_atmpt=0, state WAIT_D0; a key arriving on the expiry cycle is accepted instead, with no timeout pulse.
5. Keys 8, 8, then sensor_1=0 on the same cycle as the enter event → no try_psswrd, IDLE, outputs 0; digit keys while sensor_1=0 produce no change.
6. Keys 3, 6, then rst low asynchronously between clock edges → outputs 0 immediately; after release, state IDLE and no try_psswrd.
